// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: CPU-written pixel RAM walked one pixel per handshake, then a latch gap.
// Optional macro WS2812_BRIGHTNESS_EN adds bright[7:0] and a registered SCALE stage.
module ws2812_frame_sched #(
  parameter int NUM_LEDS     = 8,
  parameter int RESET_CYCLES = 1280,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pix_we,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_wdata,
  input  logic              start,
  input  logic              auto_en,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]        bright,
`endif
  output logic              px_valid,
  output logic [23:0]       px_data,
  output logic              px_last,
  input  logic              px_ready,
  input  logic              ser_idle,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
`ifdef WS2812_BRIGHTNESS_EN
    SCALE,
`endif
    SEND,
    DRAIN,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] index;
  logic [CNT_W-1:0] gap_cnt;
  logic             pending;
  logic             go_frame;
  logic [23:0]      mem [NUM_LEDS];
  logic [23:0]      ram_q;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction
`endif

  // Pixel RAM is deliberately not reset; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (pix_we && (int'(pix_addr) < NUM_LEDS))
      mem[pix_addr[IDX_W-1:0]] <= pix_wdata;
    if (state == FETCH)
      ram_q <= mem[index];
  end

  always_comb begin
    state_nxt = state;
    go_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (start | pending | auto_en) begin
          state_nxt = FETCH;
          go_frame  = 1'b1;
        end
      end
      FETCH: state_nxt = LOAD;
`ifdef WS2812_BRIGHTNESS_EN
      LOAD:  state_nxt = SCALE;
      SCALE: state_nxt = SEND;
`else
      LOAD:  state_nxt = SEND;
`endif
      SEND: begin
        if (px_ready)
          state_nxt = px_last ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (ser_idle)
          state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (auto_en | pending) begin
            state_nxt = FETCH;
            go_frame  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == GAP) && (gap_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      index    <= '0;
      pending  <= 1'b0;
      gap_cnt  <= '0;
      px_valid <= 1'b0;
      px_data  <= '0;
      px_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      // A start seen while busy (including the gap-exit cycle) is owed to a later frame.
      pending <= (pending & ~go_frame) | (start & busy);

      if (go_frame)
        index <= '0;
      else if ((state == SEND) && px_ready && !px_last)
        index <= index + IDX_W'(1);

      case (state)
        LOAD: begin
          px_data <= ram_q;
          px_last <= (index == LAST_IDX);
`ifndef WS2812_BRIGHTNESS_EN
          px_valid <= 1'b1;
`endif
        end
`ifdef WS2812_BRIGHTNESS_EN
        SCALE: begin
          px_data  <= {scale8(px_data[23:16], bright),
                       scale8(px_data[15:8],  bright),
                       scale8(px_data[7:0],   bright)};
          px_valid <= 1'b1;
        end
`endif
        SEND: begin
          if (px_ready)
            px_valid <= 1'b0;
        end
        DRAIN: begin
          if (ser_idle)
            gap_cnt <= GAP_LOAD;
        end
        GAP: begin
          if (gap_cnt != '0)
            gap_cnt <= gap_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ws2812_frame_sched.md
Name: ws2812_frame_sched

Overview:
Frame scheduler for the WS2812 LED chain on the PicoSoC iomem bus. Holds a NUM_LEDS x 24-bit pixel RAM that the CPU writes. On a start request or under auto-refresh, it walks the RAM and hands one pixel per handshake to the downstream WS2812 bit serializer. It then enforces the latch/reset low gap before any next frame. It owns the sequencing only; bit timing belongs to the serializer.

Parameters:
NUM_LEDS, 8, number of pixels in the chain (1..256)
RESET_CYCLES, 1280, latch gap in clk cycles after serializer goes idle (80 us at 16 MHz)
ADDR_W, 8, pixel address width; must satisfy 2**ADDR_W >= NUM_LEDS

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
pix_we  in  1  pixel RAM write strobe
pix_addr  in  ADDR_W  pixel index for write
pix_wdata  in  24  pixel value, GRB order, G in [23:16]
start  in  1  one-cycle frame request
auto_en  in  1  continuous refresh enable
px_valid  out  1  pixel offered to serializer
px_data  out  24  pixel value to serializer
px_last  out  1  marks final pixel of frame, qualified by px_valid
px_ready  in  1  serializer accepts pixel when px_valid & px_ready
ser_idle  in  1  serializer has shifted out all bits, line low
busy  out  1  high from frame start until gap complete
frame_done  out  1  one-cycle pulse when gap completes

Behaviour:
- Reset values: px_valid=0, px_data=0, px_last=0, busy=0, frame_done=0, state=IDLE, index=0, pending=0, gap counter=0. Pixel RAM is not reset; contents are undefined until written.
- RAM write: one cycle, sync. pix_addr >= NUM_LEDS is ignored. Read is synchronous with 1-cycle latency. A same-cycle read and write to the same address returns the old data.
- States:
  - IDLE: if start | pending | auto_en, clear pending, index=0, busy=1, go FETCH.
  - FETCH: issue RAM read of index, go LOAD.
  - LOAD: latch RAM data into px_data; px_valid=1; px_last=(index==NUM_LEDS-1); go SEND.
  - SEND: hold px_valid, px_data and px_last stable until px_ready. On the accept cycle, drop px_valid next cycle. If not last, increment index and go FETCH. If last, go DRAIN.
  - DRAIN: wait ser_idle=1, then load counter=RESET_CYCLES-1 and go GAP.
  - GAP: decrement each cycle. At 0, pulse frame_done, then either go FETCH with index=0 (if auto_en | pending; busy stays 1) or clear busy and go IDLE.
- Throughput: 3 cycles minimum per pixel (FETCH, LOAD, SEND with ready already high). First px_valid appears 2 cycles after start is sampled.
- start while busy: sets pending. Multiple starts collapse into one pending frame. A start in the same cycle as the GAP exit counts toward the next frame.
- auto_en deasserted mid-frame: the current frame completes, with no further frame unless pending.
- RAM write mid-frame:
  - Indices already fetched take effect next frame.
  - Indices not yet fetched take effect this frame.
  - The pixel currently latched in px_data is unaffected.
- Reset mid-frame: immediate return to IDLE with px_valid=0 asynchronously. The serializer must tolerate a dropped offer.
- NUM_LEDS=1: every pixel has px_last=1.

Optional Feature:
WS2812_BRIGHTNESS_EN:
- Adds input bright[7:0].
- Each channel is scaled as out=(c*(bright+1))>>8, using 16-bit products truncated to 8 bits. bright=255 is identity; bright=0 gives out=0 for every c.
- Scaling is registered in an extra SCALE state between LOAD and SEND, so first px_valid appears at 3 cycles and the per-pixel minimum is 4 cycles.
- Without the macro: no bright port, no SCALE state, and px_data is the raw RAM word.

Test Plan:
- Write 0x00FF00/0xFF0000/0x0000FF/0x123456 to idx 0..3 (NUM_LEDS=4), pulse start, px_ready=1, ser_idle=1 -> four accepts in order with exactly those values, px_last only on 0x123456, frame_done exactly RESET_CYCLES cycles after DRAIN entry, busy low the next cycle.
- Hold px_ready=0 for 10 cycles on pixel 1 -> px_valid, px_data and px_last are stable throughout; index does not advance; no pixel is duplicated or skipped.
- Pulse start 3 times during frame 1 -> exactly 2 frames total and 2 frame_done pulses; busy stays high across the back-to-back frames.
- auto_en=1 for 2.5 frames, then drop it -> 3 complete frames, then IDLE; write idx 3=0xABCDEF during frame 2 while index<3 -> frame 2 carries 0xABCDEF.
- Assert resetn=0 during SEND -> px_valid=0 and busy=0 immediately; after release, no output until start; write to pix_addr=NUM_LEDS -> no RAM change.
- WS2812_BRIGHTNESS_EN, bright=127, pixel 0xFF8002 -> px_data=0x7F4001; bright=0 -> 0x000000.
